// File: rtl/controle_elevador_pkg.sv
// Shared floor, direction, FSM and door codes for the elevator car controller.
package controle_elevador_pkg;

  localparam int ANDAR_W   = 2;
  localparam int NUM_ANDAR = 4;

  localparam logic [ANDAR_W-1:0] ANDAR_0 = 2'd0;
  localparam logic [ANDAR_W-1:0] ANDAR_1 = 2'd1;
  localparam logic [ANDAR_W-1:0] ANDAR_2 = 2'd2;
  localparam logic [ANDAR_W-1:0] ANDAR_3 = 2'd3;

  localparam logic SOBE  = 1'b0;
  localparam logic DESCE = 1'b1;

  localparam logic [0:0] PARADO  = 1'b0;
  localparam logic [0:0] MOVENDO = 1'b1;

  // Door FSM state code meaning fully closed; the door FSM uses the same value.
  localparam logic [1:0] PORTA_FECHADA = 2'b00;

endpackage

// File: rtl/controle_elevador_seletor_alvo.sv
// Combinational collective target selection: current floor first, then the
// nearest request in the travel direction, then the nearest one behind.
module seletor_alvo
  import controle_elevador_pkg::*;
(
  input  logic [3:0] pend_i,
  input  logic [1:0] ba_i,
  input  logic       direcao_i,
  output logic [1:0] alvo_o
);

  logic                up_ok;
  logic                dn_ok;
  logic [ANDAR_W-1:0]  up_a;
  logic [ANDAR_W-1:0]  dn_a;

  // Scanning from the far end towards the car leaves the nearest hit in place.
  always_comb begin
    up_ok = 1'b0;
    up_a  = ba_i;
    for (int i = NUM_ANDAR - 1; i >= 0; i--) begin
      if ((ANDAR_W'(i) > ba_i) && pend_i[i]) begin
        up_ok = 1'b1;
        up_a  = ANDAR_W'(i);
      end
    end
    dn_ok = 1'b0;
    dn_a  = ba_i;
    for (int i = 0; i < NUM_ANDAR; i++) begin
      if ((ANDAR_W'(i) < ba_i) && pend_i[i]) begin
        dn_ok = 1'b1;
        dn_a  = ANDAR_W'(i);
      end
    end
  end

  always_comb begin
    alvo_o = ba_i;
    if (pend_i[ba_i]) begin
      alvo_o = ba_i;
    end else if (direcao_i == SOBE) begin
      if (up_ok)      alvo_o = up_a;
      else if (dn_ok) alvo_o = dn_a;
    end else begin
      if (dn_ok)      alvo_o = dn_a;
      else if (up_ok) alvo_o = up_a;
    end
  end

endmodule

// File: rtl/controle_elevador.sv
// Car controller: latches calls, picks the target floor BP and moves the car
// floor by floor while the door FSM reports fully closed.
module controle_elevador
  import controle_elevador_pkg::*;
#(
  parameter int TICKS_ANDAR = 2,
  parameter int N_ANDARES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       P,
  input  logic [1:0] porta_estado,
  output logic [1:0] BA,
  output logic [1:0] BP,
  output logic       movendo,
  output logic       direcao,
  output logic [3:0] pendentes
);

  localparam int CNT_W = (TICKS_ANDAR > 1) ? $clog2(TICKS_ANDAR) : 1;
  localparam logic [CNT_W-1:0] CNT_RECARGA = CNT_W'(TICKS_ANDAR - 1);

  logic [N_ANDARES-1:0] pend_q, pend_d, clr;
  logic [ANDAR_W-1:0]   ba_q, ba_d, bp_q, bp_d, ba_prox, alvo;
  logic                 dir_q, dir_d;
  logic                 mov_q, mov_d;
  logic [0:0]           estado_q, estado_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 porta_fechada;

  seletor_alvo u_seletor (
    .pend_i    (pend_q),
    .ba_i      (ba_q),
    .direcao_i (dir_q),
    .alvo_o    (alvo)
  );

  assign porta_fechada = (porta_estado == PORTA_FECHADA);

  // Clearing the served floor wins over a press of the same button.
  always_comb begin
    clr    = P ? (N_ANDARES'(1) << ba_q) : '0;
    pend_d = (pend_q | botoes) & ~clr;
    bp_d   = alvo;
  end

  always_comb begin
    estado_d = estado_q;
    ba_d     = ba_q;
    dir_d    = dir_q;
    mov_d    = mov_q;
    cnt_d    = cnt_q;
    ba_prox  = (dir_q == DESCE) ? ba_q - 2'd1 : ba_q + 2'd1;
    case (estado_q)
      PARADO: begin
        if (porta_fechada && (bp_q != ba_q)) begin
          dir_d    = (bp_q < ba_q) ? DESCE : SOBE;
          cnt_d    = CNT_RECARGA;
          mov_d    = 1'b1;
          estado_d = MOVENDO;
        end
      end
      MOVENDO: begin
        // An open or opening door freezes the trip where it is.
        if (!porta_fechada) begin
          cnt_d = cnt_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ba_d = ba_prox;
          if ((ba_prox == bp_q) ||
              ((dir_q == SOBE)  && (ba_prox == ANDAR_3)) ||
              ((dir_q == DESCE) && (ba_prox == ANDAR_0))) begin
            mov_d    = 1'b0;
            estado_d = PARADO;
          end else begin
            cnt_d = CNT_RECARGA;
          end
        end
      end
      default: estado_d = PARADO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      ba_q     <= ANDAR_0;
      bp_q     <= ANDAR_0;
      dir_q    <= SOBE;
      mov_q    <= 1'b0;
      estado_q <= PARADO;
      cnt_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      ba_q     <= ba_d;
      bp_q     <= bp_d;
      dir_q    <= dir_d;
      mov_q    <= mov_d;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  assign BA        = ba_q;
  assign BP        = bp_q;
  assign movendo   = mov_q;
  assign direcao   = dir_q;
  assign pendentes = pend_q;

endmodule

// File: tb/tb_controle_elevador.sv
// Directed bench for the elevator car controller with an expectation queue.
module tb_controle_elevador;

  localparam int F_BA   = 0;
  localparam int F_BP   = 1;
  localparam int F_MOV  = 2;
  localparam int F_DIR  = 3;
  localparam int F_PEND = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       P;
  logic [1:0] porta_estado;
  logic [1:0] BA, BP;
  logic       movendo, direcao;
  logic [3:0] pendentes;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         fld;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  controle_elevador #(.TICKS_ANDAR(2), .N_ANDARES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .botoes       (botoes),
    .P            (P),
    .porta_estado (porta_estado),
    .BA           (BA),
    .BP           (BP),
    .movendo      (movendo),
    .direcao      (direcao),
    .pendentes    (pendentes)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] obs(int f);
    case (f)
      F_BA:    return {2'b00, BA};
      F_BP:    return {2'b00, BP};
      F_MOV:   return {3'b000, movendo};
      F_DIR:   return {3'b000, direcao};
      default: return pendentes;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int fld, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.val = v;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare every expectation queued for that edge.
  task automatic step();
    exp_t       e;
    logic [3:0] o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.fld);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    botoes = 4'b0000;
    P = 1'b0;
    porta_estado = 2'b00;
    expect_v({tag, "_BA"},   F_BA,   4'h0);
    expect_v({tag, "_BP"},   F_BP,   4'h0);
    expect_v({tag, "_pend"}, F_PEND, 4'h0);
    expect_v({tag, "_mov"},  F_MOV,  4'h0);
    expect_v({tag, "_dir"},  F_DIR,  4'h0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    botoes = 4'b0000;
    P = 1'b0;
    porta_estado = 2'b00;
    do_reset("rst0");

    // Single call to floor 3 from floor 0.
    botoes = 4'b1000;
    expect_v("sc_pend", F_PEND, 4'b1000);
    expect_v("sc_bp_lat", F_BP, 4'h0);
    step();
    botoes = 4'b0000;
    expect_v("sc_bp3", F_BP, 4'h3);
    expect_v("sc_idle", F_MOV, 4'h0);
    step();
    expect_v("sc_mov", F_MOV, 4'h1);
    expect_v("sc_ba0", F_BA, 4'h0);
    expect_v("sc_dir", F_DIR, 4'h0);
    step();
    step();
    expect_v("sc_ba1", F_BA, 4'h1);
    step();
    step();
    expect_v("sc_ba2", F_BA, 4'h2);
    step();
    step();
    expect_v("sc_ba3", F_BA, 4'h3);
    expect_v("sc_arr", F_MOV, 4'h0);
    expect_v("sc_bp_arr", F_BP, 4'h3);
    step();
    P = 1'b1;
    expect_v("sc_clr", F_PEND, 4'b0000);
    step();
    P = 1'b0;
    expect_v("sc_bp_hold", F_BP, 4'h3);
    expect_v("sc_rest", F_MOV, 4'h0);
    step();

    // Retarget at floor 1 while the door interlock freezes the trip.
    do_reset("rst1");
    botoes = 4'b1000;
    step();
    botoes = 4'b0000;
    expect_v("rt_bp3", F_BP, 4'h3);
    step();
    expect_v("rt_mov", F_MOV, 4'h1);
    step();
    step();
    expect_v("rt_ba1", F_BA, 4'h1);
    step();
    botoes = 4'b0100;
    porta_estado = 2'b01;
    expect_v("rt_pend", F_PEND, 4'b1100);
    expect_v("il_ba_f1", F_BA, 4'h1);
    step();
    botoes = 4'b0000;
    expect_v("rt_bp2", F_BP, 4'h2);
    expect_v("il_ba_f2", F_BA, 4'h1);
    step();
    expect_v("il_ba_f3", F_BA, 4'h1);
    step();
    porta_estado = 2'b00;
    expect_v("il_ba_f4", F_BA, 4'h1);
    expect_v("il_mov", F_MOV, 4'h1);
    step();
    expect_v("rt_ba2", F_BA, 4'h2);
    expect_v("rt_stop", F_MOV, 4'h0);
    expect_v("rt_bp_stop", F_BP, 4'h2);
    step();
    P = 1'b1;
    porta_estado = 2'b01;
    expect_v("rt_clr2", F_PEND, 4'b1000);
    expect_v("rt_bp_still2", F_BP, 4'h2);
    step();
    P = 1'b0;
    expect_v("rt_bp_back3", F_BP, 4'h3);
    expect_v("il_park1", F_MOV, 4'h0);
    step();
    expect_v("il_park_ba", F_BA, 4'h2);
    expect_v("il_park2", F_MOV, 4'h0);
    step();
    porta_estado = 2'b00;
    expect_v("rt_resume", F_MOV, 4'h1);
    expect_v("rt_dir", F_DIR, 4'h0);
    step();
    step();
    expect_v("rt_ba3", F_BA, 4'h3);
    expect_v("rt_arr3", F_MOV, 4'h0);
    step();

    // Direction keep: at floor 2 going up with calls at 3 and 0.
    do_reset("rst2");
    botoes = 4'b0100;
    step();
    botoes = 4'b0000;
    expect_v("dk_bp2", F_BP, 4'h2);
    step();
    expect_v("dk_mov", F_MOV, 4'h1);
    step();
    step();
    expect_v("dk_ba1", F_BA, 4'h1);
    step();
    step();
    expect_v("dk_ba2", F_BA, 4'h2);
    expect_v("dk_stop2", F_MOV, 4'h0);
    step();
    P = 1'b1;
    botoes = 4'b1001;
    expect_v("dk_pend", F_PEND, 4'b1001);
    step();
    P = 1'b0;
    botoes = 4'b0000;
    expect_v("dk_bp3", F_BP, 4'h3);
    expect_v("dk_dir_up", F_DIR, 4'h0);
    step();
    expect_v("dk_dep_up", F_MOV, 4'h1);
    expect_v("dk_dir_up2", F_DIR, 4'h0);
    step();
    step();
    expect_v("dk_ba3", F_BA, 4'h3);
    expect_v("dk_arr3", F_MOV, 4'h0);
    step();
    P = 1'b1;
    expect_v("dk_clr3", F_PEND, 4'b0001);
    expect_v("dk_bp_hold3", F_BP, 4'h3);
    step();
    P = 1'b0;
    expect_v("dk_bp0", F_BP, 4'h0);
    step();
    expect_v("dk_dir_dn", F_DIR, 4'h1);
    expect_v("dk_dep_dn", F_MOV, 4'h1);
    step();
    step();
    expect_v("dk_dn_ba2", F_BA, 4'h2);
    step();
    step();
    expect_v("dk_dn_ba1", F_BA, 4'h1);
    step();
    step();
    expect_v("dk_dn_ba0", F_BA, 4'h0);
    expect_v("dk_arr0", F_MOV, 4'h0);
    step();
    P = 1'b1;
    expect_v("dk_clr0", F_PEND, 4'b0000);
    step();
    P = 1'b0;

    // Clear beats set on the served floor; other bits still latch.
    do_reset("rst3");
    botoes = 4'b0010;
    step();
    botoes = 4'b0000;
    expect_v("cs_bp1", F_BP, 4'h1);
    step();
    expect_v("cs_mov", F_MOV, 4'h1);
    step();
    step();
    expect_v("cs_ba1", F_BA, 4'h1);
    expect_v("cs_stop", F_MOV, 4'h0);
    step();
    P = 1'b1;
    botoes = 4'b0011;
    expect_v("cs_pend", F_PEND, 4'b0001);
    step();
    P = 1'b0;
    botoes = 4'b0000;
    expect_v("cs_bp0", F_BP, 4'h0);
    step();
    expect_v("mt_mov", F_MOV, 4'h1);
    expect_v("mt_dir", F_DIR, 4'h1);
    step();

    // Reset asserted mid-travel.
    do_reset("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_elevador.md
Name: controle_elevador

Overview:
- Car-side controller that produces the floor code pair consumed by the door FSM: current floor BA and priority/target floor BP.
- Latches hall/cabin call buttons for 4 floors and selects the next target with a collective (keep-direction) policy.
- Moves the car one floor per TICKS_ANDAR slow-clock ticks, and only while the door FSM reports fully closed.
- Clears a floor's request when the door reports open (P). Sits between the button debouncers and the door FSM, clocked by the 1 s divided clock.

Parameters:
- TICKS_ANDAR, 2, clk cycles to travel one floor (>=1).
- N_ANDARES, 4, number of floors. Fixed by the 2-bit floor code and not to be overridden.

Ports:
- clk  in  1  divided clock, one tick per second.
- reset  in  1  synchronous, active-high; acts on the rising edge of clk.
- botoes  in  4  call buttons, bit i = floor i, level-sensitive; OR'ed into the requests every cycle.
- P  in  1  door fully open, from the door FSM.
- porta_estado  in  2  door FSM state code; 00 = fully closed.
- BA  out  2  current floor (BA[1]=BA1, BA[0]=BA0).
- BP  out  2  priority/target floor (BP[1]=BP1, BP[0]=BP0).
- movendo  out  1  car between floors.
- direcao  out  1  0 = up, 1 = down.
- pendentes  out  4  latched request vector.

Behaviour:
- Reset (sync, high) sets: BA=0, BP=0, pendentes=0, direcao=0, movendo=0, FSM=PARADO, travel counter=0. Reset has priority over every other event, including reset asserted mid-travel.
- Request register, each cycle: pend_next = (pend | botoes) & ~clr.
  - clr = onehot(BA) when P=1, else 0.
  - Clear beats set on the same bit in the same cycle.
- Target select is combinational on the registered pend, BA and direcao; BP is registered, giving 1 cycle of latency. Priority order:
  1. pend[BA]=1 -> BA.
  2. Requests exist in direcao -> nearest such floor.
  3. Requests exist only in the opposite direction -> nearest there.
  4. No requests -> BA.
- BP=BA while idle is intentional: the door rests open at the idle floor.
- FSM PARADO:
  - Leaves only if porta_estado==00 and BP!=BA.
  - On leaving: direcao <= (BP<BA), counter <= TICKS_ANDAR-1, movendo <= 1, next state MOVENDO.
- FSM MOVENDO:
  - If porta_estado!=00 (e.g. door forced by full-car input), freeze the counter and BA.
  - Else if counter>0, decrement.
  - Else (counter==0): BA <= BA+1 if up, BA-1 if down.
    - If the new BA equals BP, or is floor 3 going up / floor 0 going down -> PARADO, movendo <= 0.
    - Otherwise reload the counter and continue.
- Direction is committed during travel: direcao changes only in PARADO. BP may retarget to a nearer floor in the same direction mid-travel, and the car stops there.
- BA never wraps; the boundaries are 0 and 3.
- The door FSM opens when BA==BP after arrival. P=1 clears pend[BA]; BP is recomputed the next cycle. The car departs only when porta_estado returns to 00.

Decomposition:
- Shared package holds:
  - Floor code width 2.
  - Constants ANDAR_0..ANDAR_3.
  - Direction constants SOBE=0 and DESCE=1.
  - FSM codes PARADO and MOVENDO.
  - PORTA_FECHADA=2'b00, shared with the door FSM.
- One sub-module: seletor_alvo, purely combinational nearest-request selection (pend, BA, direcao -> alvo). It is verified standalone.

Test Plan:
- Reset: assert reset 1 cycle at any state -> BA=00, BP=00, pendentes=0000, movendo=0, direcao=0 after that edge.
- Single call: BA=0, porta_estado=00, botoes=1000 for 1 cycle.
  - pendentes=1000 at the next edge; BP=3 one edge later; movendo=1.
  - BA=1, 2, 3 at 2-cycle intervals; movendo=0 on arrival at 3.
  - Drive P=1 -> pendentes=0000, BP stays 3.
- Retarget: travelling 0->3 and BA=1, press botoes=0100 -> BP=2, car stops at 2. After P=1, pend[2] clears, BP returns to 3 and the car resumes once porta_estado=00.
- Direction keep: BA=2, direcao=up, pendentes=1001 -> BP=3 first, serve 3 with P, then BP=0, direcao=1, BA descends 2, 1, 0.
- Door interlock: porta_estado=01 for 3 cycles during MOVENDO -> counter and BA frozen for those 3 cycles, travel completes 3 cycles late. In PARADO with porta_estado!=00 and BP!=BA -> no departure.
- Clear vs set: BA=1, P=1 and botoes=0010 in the same cycle -> pend[1]=0 after the edge.
